hid_display_scheduler: RTL and testbench
========================================

Name: hid_display_scheduler

Overview:
- Shares the single 64-bit hex display register between up to C_channels HID host report sources.
- Latches each channel's latest report and commits at most one report per video frame to the display register, so on-screen digits never tear mid-frame.
- Chooses the channel with a round-robin policy plus a minimum hold time.
- Sits between the usbh_host_hid instances (already synchronised into the pixel domain) and hex_decoder_v; runs on the pixel clock.

Parameters:
- C_channels, 3, number of report sources (1..8).
- C_report_bits, 64, width of one report and of display_data.
- C_hold_frames, 60, minimum frames a newly switched-to channel stays displayed before another channel may take over (>=1).

Ports:
- clk  in  1  pixel clock; all inputs are synchronous to it.
- rstn  in  1  synchronous active-low reset.
- report_data  in  C_channels*C_report_bits  flat report bus; channel i occupies bits [i*C_report_bits +: C_report_bits].
- report_valid  in  C_channels  one-cycle strobe per channel; new report present.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- clear_overrun  in  1  clears all overrun flags.
- display_data  out  C_report_bits  report currently shown.
- display_chan  out  clog2(C_channels), min 1  channel that owns display_data.
- display_update  out  1  one-cycle pulse when display_data changes.
- pending  out  C_channels  per-channel unconsumed-report flags.
- overrun  out  C_channels  sticky: report overwritten before being displayed.

Behaviour:
- Reset (rstn=0 at a clk edge) clears all of the following to 0:
  - display_data, display_chan, display_update, pending, overrun, hold counter;
  - slot registers, FSM -> IDLE.
  - Exception: last_chan resets to C_channels-1, so the first round-robin pick is channel 0.
  - Reset mid-ARB/COMMIT aborts the commit; display_data stays 0.
- Capture (every state):
  - report_valid[i] -> slot[i] <= channel i data; pending[i] <= 1.
  - If pending[i] was already 1 and is not being cleared this cycle, overrun[i] <= 1.
  - clear_overrun clears overrun; a same-cycle overrun set wins over the clear.
- FSM IDLE:
  - frame_start with any pending -> ARB; otherwise stay IDLE.
  - On every frame_start (any pending or not), the hold counter decrements if nonzero.
- FSM ARB (1 cycle): pick grant g.
  - If pending[display_chan] is set, g = display_chan (the owner always refreshes).
  - Else if hold counter = 0, g = first pending channel searching last_chan+1, +2, ... with wrap.
  - Else no grant -> IDLE.
- FSM COMMIT (1 cycle):
  - display_data <= slot[g]; display_chan <= g; display_update = 1; last_chan <= g.
  - Clear pending[g], unless report_valid[g] is high in the same cycle: the slot then takes the new data, pending stays 1, display shows the old slot value, and no overrun is flagged.
  - If g != previous display_chan, hold counter <= C_hold_frames-1.
  - Next state -> IDLE.
- Latency: frame_start at cycle T -> display_data / display_update at T+2.
- frame_start arriving in ARB or COMMIT is ignored; it does not count toward hold.
- At most one commit per frame.
- Unused channels: report_valid is tied 0 by the instantiator.

Decomposition:
- Package hid_sched_pkg: state enum (IDLE, ARB, COMMIT), function clog2, constant C_CHAN_W.
- One sub-module, hid_rr_pick: combinational round-robin search over the pending mask from last_chan+1.
  - Inputs: pending, last_chan. Outputs: grant index, grant_valid.
  - Instantiated once, registered in ARB.

Test Plan:
- Reset, then valid[0] with 64'h0123_4567_89AB_CDEF, then frame_start at T -> display_data matches at T+2, display_chan=0, display_update exactly 1 cycle, pending=0.
- C_hold_frames=3: channel 0 displayed, then valid[1] each frame -> channel 1 is granted on the 3rd frame_start after the switch, not before.
- pending[0] and pending[2] both set, hold expired, last_chan=0 -> channel 2 wins; on a later frame with 0 and 1 pending -> channel 0 wins (wrap).
- valid[1] twice before any frame_start -> overrun[1]=1, display shows the second report; clear_overrun -> overrun=0.
- report_valid[g] in the COMMIT cycle -> old value displayed, pending[g] remains 1, next frame shows the new value, overrun stays 0.
- rstn low in the ARB cycle -> no display_update, all outputs 0, next frame with pending rearbitrates from channel 0.

Source files
------------

// File: rtl/hid_sched_pkg.sv
// Shared types and helpers for the HID report display scheduler.
package hid_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    COMMIT
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Index width for n channels; a single channel still gets a 1-bit index.
  function automatic int unsigned chan_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int unsigned C_MAX_CHANNELS = 8;
  localparam int unsigned C_CHAN_W       = clog2(C_MAX_CHANNELS);

endpackage

// File: rtl/hid_rr_pick.sv
// Combinational round-robin search: first pending channel after last_chan, with wrap.
module hid_rr_pick
  import hid_sched_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = C_CHAN_W
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] last_chan,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!grant_valid && pending[i] && (i == ((32'(last_chan) + k) % N))) begin
          grant       = W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hid_display_scheduler.sv
// Shares one hex display register between several HID report sources,
// committing at most one latched report per video frame.
module hid_display_scheduler
  import hid_sched_pkg::*;
#(
  parameter int unsigned C_channels    = 3,
  parameter int unsigned C_report_bits = 64,
  parameter int unsigned C_hold_frames = 60
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [C_channels*C_report_bits-1:0] report_data,
  input  logic [C_channels-1:0]               report_valid,
  input  logic                                frame_start,
  input  logic                                clear_overrun,
  output logic [C_report_bits-1:0]            display_data,
  output logic [chan_w(C_channels)-1:0]       display_chan,
  output logic                                display_update,
  output logic [C_channels-1:0]               pending,
  output logic [C_channels-1:0]               overrun
);

  localparam int unsigned   CW        = chan_w(C_channels);
  localparam int unsigned   HW        = chan_w(C_hold_frames);
  localparam logic [CW-1:0] LAST_RST  = CW'(C_channels - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(C_hold_frames - 1);

  state_t                   state, state_next;
  logic [C_report_bits-1:0] slot [C_channels];
  logic [CW-1:0]            last_chan, grant_q, pick, arb_chan;
  logic                     pick_valid, arb_grant, committing;
  logic [HW-1:0]            hold;
  logic [C_channels-1:0]    pending_next, overrun_next;

  assign committing = (state == COMMIT);

  hid_rr_pick #(
    .N(C_channels),
    .W(CW)
  ) u_pick (
    .pending    (pending),
    .last_chan  (last_chan),
    .grant      (pick),
    .grant_valid(pick_valid)
  );

  always_comb begin
    state_next = state;
    arb_grant  = 1'b0;
    arb_chan   = display_chan;
    unique case (state)
      IDLE: if (frame_start && (|pending)) state_next = ARB;
      ARB: begin
        // The current owner always refreshes; others wait for the hold to expire.
        if (pending[display_chan]) begin
          arb_grant = 1'b1;
          arb_chan  = display_chan;
        end else if ((hold == '0) && pick_valid) begin
          arb_grant = 1'b1;
          arb_chan  = pick;
        end
        state_next = arb_grant ? COMMIT : IDLE;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A report landing on the granted channel during commit keeps it pending without overrun.
  always_comb begin
    logic clr;
    clr          = 1'b0;
    pending_next = pending;
    overrun_next = overrun;
    if (clear_overrun) overrun_next = '0;
    for (int unsigned i = 0; i < C_channels; i++) begin
      clr = committing && (grant_q == CW'(i));
      if (clr) pending_next[i] = 1'b0;
      if (report_valid[i]) begin
        pending_next[i] = 1'b1;
        if (pending[i] && !clr) overrun_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      display_data   <= '0;
      display_chan   <= '0;
      display_update <= 1'b0;
      pending        <= '0;
      overrun        <= '0;
      hold           <= '0;
      grant_q        <= '0;
      last_chan      <= LAST_RST;
      for (int unsigned i = 0; i < C_channels; i++) slot[i] <= '0;
    end else begin
      state          <= state_next;
      display_update <= 1'b0;
      pending        <= pending_next;
      overrun        <= overrun_next;
      if (state == ARB) grant_q <= arb_chan;
      if ((state == IDLE) && frame_start && (hold != '0)) hold <= hold - HW'(1);
      if (committing) begin
        display_data   <= slot[grant_q];
        display_chan   <= grant_q;
        display_update <= 1'b1;
        last_chan      <= grant_q;
        if (grant_q != display_chan) hold <= HOLD_LOAD;
      end
      for (int unsigned i = 0; i < C_channels; i++) begin
        if (report_valid[i]) slot[i] <= report_data[i*C_report_bits +: C_report_bits];
      end
    end
  end

endmodule

// File: tb/tb_hid_display_scheduler.sv
// Scoreboard bench for hid_display_scheduler: expected commits queued per frame.
module tb_hid_display_scheduler;

  localparam int unsigned NCH  = 3;
  localparam int unsigned RB   = 64;
  localparam int unsigned HOLD = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NCH*RB-1:0] report_data = '0;
  logic [NCH-1:0]    report_valid = '0;
  logic              frame_start = 1'b0;
  logic              clear_overrun = 1'b0;
  logic [RB-1:0]     display_data;
  logic [1:0]        display_chan;
  logic              display_update;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    overrun;

  hid_display_scheduler #(
    .C_channels   (NCH),
    .C_report_bits(RB),
    .C_hold_frames(HOLD)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .report_data   (report_data),
    .report_valid  (report_valid),
    .frame_start   (frame_start),
    .clear_overrun (clear_overrun),
    .display_data  (display_data),
    .display_chan  (display_chan),
    .display_update(display_update),
    .pending       (pending),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  chan;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_slot [NCH];
  exp_t        exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input int ch, input logic [63:0] d);
    @(negedge clk);
    report_data[ch*RB +: RB] = d;
    report_valid[ch]         = 1'b1;
    model_slot[ch]           = d;
    @(negedge clk);
    report_valid = '0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
  endtask

  // Frame pulse; commit expected two edges later, update must last one cycle.
  task automatic frame(input bit exp_commit, input int exp_ch, input string tag,
                       input int inj_ch = -1, input logic [63:0] inj_d = '0);
    exp_t e;
    if (exp_commit) begin
      e.data = model_slot[exp_ch];
      e.chan = 2'(exp_ch);
      exp_q.push_back(e);
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, "_upd_t1"}, 64'(display_update), 64'd0);
    @(negedge clk);
    check({tag, "_upd_t2"}, 64'(display_update), 64'd0);
    if (inj_ch >= 0) begin
      report_data[inj_ch*RB +: RB] = inj_d;
      report_valid[inj_ch]         = 1'b1;
      model_slot[inj_ch]           = inj_d;
    end
    @(negedge clk);
    report_valid = '0;
    check({tag, "_upd"}, 64'(display_update), 64'(exp_commit));
    if (exp_commit && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, display_data, e.data);
      check({tag, "_chan"}, 64'(display_chan), 64'(e.chan));
    end
    @(negedge clk);
    check({tag, "_upd_t4"}, 64'(display_update), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"}, display_data, 64'd0);
    check({tag, "_chan"}, 64'(display_chan), 64'd0);
    check({tag, "_upd"}, 64'(display_update), 64'd0);
    check({tag, "_pend"}, 64'(pending), 64'd0);
    check({tag, "_ovr"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NCH; i++) model_slot[i] = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rstn = 1'b1;

    // First commit: owner channel 0 after reset, latency T+2.
    send(0, 64'h0123_4567_89AB_CDEF);
    check("p_after_send0", 64'(pending), 64'h1);
    frame(1, 0, "first");
    check("p_after_first", 64'(pending), 64'h0);
    check("o_after_first", 64'(overrun), 64'h0);

    // Switch to channel 1 loads the hold; channel 0 waits two more frame_starts.
    send(1, 64'hAAAA_0000_0000_0001);
    frame(1, 1, "sw1");
    send(0, 64'hBBBB_0000_0000_0002);
    frame(0, 0, "hold1");
    check("p_hold1", 64'(pending), 64'h1);
    check("chan_hold1", 64'(display_chan), 64'd1);
    frame(1, 0, "hold2");

    send(1, 64'hCCCC_0000_0000_0003);
    frame(0, 0, "h3a");
    frame(1, 1, "h3b");
    frame(0, 0, "idle1");
    frame(0, 0, "idle2");

    // Round robin from last_chan=1: channel 2 beats 0, then wrap to 0 beats 1.
    send(0, 64'hDDDD_0000_0000_0004);
    send(2, 64'hEEEE_0000_0000_0005);
    frame(1, 2, "rr2");
    check("p_rr2", 64'(pending), 64'h1);
    send(1, 64'hFFFF_0000_0000_0006);
    frame(0, 0, "rrh");
    frame(1, 0, "rrwrap");
    check("p_rrwrap", 64'(pending), 64'h2);
    frame(0, 0, "rrh2");
    frame(1, 1, "rr1");
    check("p_rr1", 64'(pending), 64'h0);

    // Overrun: second report before display replaces the first.
    send(1, 64'h1111_2222_3333_4444);
    check("o_first", 64'(overrun), 64'h0);
    send(1, 64'h5555_6666_7777_8888);
    check("o_second", 64'(overrun), 64'h2);
    check("p_second", 64'(pending), 64'h2);
    frame(1, 1, "ovr");
    check("o_sticky", 64'(overrun), 64'h2);
    pulse_clear();
    check("o_cleared", 64'(overrun), 64'h0);

    // Overrun set and clear in the same cycle: the set wins.
    send(1, 64'h9999_0000_0000_0001);
    @(negedge clk);
    report_data[1*RB +: RB] = 64'h9999_0000_0000_0002;
    report_valid[1]         = 1'b1;
    model_slot[1]           = 64'h9999_0000_0000_0002;
    clear_overrun           = 1'b1;
    @(negedge clk);
    report_valid  = '0;
    clear_overrun = 1'b0;
    check("o_setwins", 64'(overrun), 64'h2);
    pulse_clear();
    check("o_cleared2", 64'(overrun), 64'h0);
    frame(1, 1, "ovr2");

    // New report on the granted channel in the commit cycle.
    send(1, 64'h0000_0000_0000_0A0A);
    frame(1, 1, "cc", 1, 64'h0000_0000_0000_0B0B);
    check("p_cc", 64'(pending), 64'h2);
    check("o_cc", 64'(overrun), 64'h0);
    frame(1, 1, "cc_next");
    check("p_cc_next", 64'(pending), 64'h0);
    check("o_cc_next", 64'(overrun), 64'h0);

    // Reset asserted during the arbitration cycle aborts the commit.
    send(2, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    rstn        = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NCH; i++) model_slot[i] = '0;
    @(negedge clk);
    check_cleared("rst_arb");

    // Search restarts at channel 0, so channel 1 beats channel 2.
    send(1, 64'h0101_0101_0101_0101);
    send(2, 64'h0202_0202_0202_0202);
    frame(1, 1, "post_rst");
    check("p_post_rst", 64'(pending), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
